mapper_megaram_gen: RTL and testbench



---
 rtl/mapper_megaram_gen_if.sv | 31 +++
 rtl/mapper_megaram_gen.sv | 102 ++++++++++
 tb/tb_mapper_megaram_gen.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mapper_megaram_gen_if.sv
// MegaRAM mapper bus bundle: CPU-side request signals and RAM-side results.
// master drives the CPU side (host/bench); slave is the mapper itself.
interface mapper_megaram_gen_if;
  logic        cs;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_req;
  logic        cpu_wr;
  logic        cpu_mreq;
  logic        cpu_iorq;
  logic [26:0] base_addr;
  logic        out_ram_cs;
  logic        out_rnw;
  logic [26:0] out_addr;
  logic [7:0]  out_data;
  logic        mode_ram;

  modport master (
    output cs, cpu_addr, cpu_data, cpu_req,
    output cpu_wr, cpu_mreq, cpu_iorq, base_addr,
    input  out_ram_cs, out_rnw, out_addr,
    input  out_data, mode_ram
  );

  modport slave (
    input  cs, cpu_addr, cpu_data, cpu_req,
    input  cpu_wr, cpu_mreq, cpu_iorq, base_addr,
    output out_ram_cs, out_rnw, out_addr,
    output out_data, mode_ram
  );
endinterface

// File: rtl/mapper_megaram_gen.sv
// MegaRAM mapper: four 8 KB banks at 4000h-BFFFh, bank/RAM mode via port 8Eh.
// Ports: clk, reset (sync, active-high), bus (mapper_megaram_gen_if.slave).
// Build option: MEGARAM_PORT_MIRROR_EN also decodes the port at 8Fh.
module mapper_megaram_gen #(
  parameter int SIZE_KB   = 256,
  parameter int BANK_BITS = 8
) (
  input  logic clk,
  input  logic reset,
  mapper_megaram_gen_if.slave bus
);

  localparam int PAGES = SIZE_KB / 8;
  localparam logic [BANK_BITS-1:0] PAGE_MASK = BANK_BITS'(PAGES - 1);

  logic [BANK_BITS-1:0] bank_q [4];
  logic                 req_q;
  logic                 req_blk_q;
  logic                 mode_q;
  logic                 mode_d;

  logic                 in_win;
  logic [1:0]           idx;
  logic                 port_hit;
  logic                 rise;
  logic                 mem_hit;
  logic                 bank_ld;
  logic [BANK_BITS-1:0] wr_val;
  logic [BANK_BITS+12:0] offs;
  logic [26:0]          phys;

  assign in_win = (bus.cpu_addr[15:14] == 2'b01) |
                  (bus.cpu_addr[15:14] == 2'b10);

  // 010->0, 011->1, 100->2, 101->3 (page number minus two)
  assign idx = {bus.cpu_addr[15], bus.cpu_addr[13]};

`ifdef MEGARAM_PORT_MIRROR_EN
  assign port_hit = bus.cpu_iorq & (bus.cpu_addr[7:1] == 7'h47);
`else
  assign port_hit = bus.cpu_iorq & (bus.cpu_addr[7:0] == 8'h8E);
`endif

  // req_blk_q masks an access that was already running across reset
  assign rise    = bus.cpu_req & ~req_q & ~req_blk_q;
  assign mem_hit = bus.cs & bus.cpu_mreq & bus.cpu_req &
                   in_win & ~bus.cpu_iorq;
  assign bank_ld = rise & mem_hit & bus.cpu_wr & ~mode_q;
  assign wr_val  = BANK_BITS'(bus.cpu_data);

  assign offs = {bank_q[idx] & PAGE_MASK, bus.cpu_addr[12:0]};
  assign phys = bus.base_addr + 27'(offs);

  always_ff @(posedge clk) begin
    if (reset) begin
      req_q     <= 1'b0;
      req_blk_q <= bus.cpu_req;
    end else begin
      req_q <= bus.cpu_req;
      if (!bus.cpu_req)
        req_blk_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 4; i++)
        bank_q[i] <= BANK_BITS'(i);
    end else if (bank_ld) begin
      bank_q[idx] <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)
      mode_q <= 1'b0;
    else
      mode_q <= mode_d;
  end

  always_comb begin
    mode_d = mode_q;
    if (rise && port_hit)
      mode_d = bus.cpu_wr;
  end

  always_comb begin
    bus.out_ram_cs = 1'b0;
    bus.out_rnw    = 1'b1;
    bus.out_addr   = '1;
    bus.out_data   = 8'hFF;
    bus.mode_ram   = mode_q;
    if (!reset && mem_hit && (!bus.cpu_wr || mode_q)) begin
      bus.out_ram_cs = 1'b1;
      bus.out_rnw    = ~bus.cpu_wr;
      bus.out_addr   = phys;
      if (bus.cpu_wr)
        bus.out_data = bus.cpu_data;
    end
  end

endmodule

// File: tb/tb_mapper_megaram_gen.sv
// Bench for mapper_megaram_gen: directed table, hand sequences, random vs model.
// Model keeps banks/mode as plain integers and recomputes addresses arithmetically.
module tb_mapper_megaram_gen;

  localparam int SIZE_KB   = 256;
  localparam int BANK_BITS = 8;
  localparam int PAGES     = SIZE_KB / 8;
`ifdef MEGARAM_PORT_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  typedef struct {
    bit          io;
    bit          mr;
    bit          c;
    bit          wr;
    logic [15:0] a;
    logic [7:0]  d;
    logic [26:0] b;
    int          hold;
    bit          exp_cs;
    bit          exp_rnw;
    logic [26:0] exp_addr;
    logic [7:0]  exp_d;
    bit          exp_mode;
  } vec_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mapper_megaram_gen_if bus ();

  mapper_megaram_gen #(
    .SIZE_KB  (SIZE_KB),
    .BANK_BITS(BANK_BITS)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  int bank_m [4];
  bit mode_m;

  localparam logic [26:0] NA = 27'h7FFFFFF;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  function automatic bit in_win(input logic [15:0] a);
    return a >= 16'h4000 && a <= 16'hBFFF;
  endfunction

  function automatic int win_idx(input logic [15:0] a);
    return int'(a) / 8192 - 2;
  endfunction

  function automatic bit port_m(input logic [15:0] a);
    int lo = int'(a) % 256;
    return lo == 'h8E || (MIRROR && lo == 'h8F);
  endfunction

  function automatic logic [26:0] phys_m(input logic [15:0] a,
                                         input logic [26:0] b);
    longint s;
    s = longint'(b) + longint'(bank_m[win_idx(a)] % PAGES) * 8192
        + longint'(int'(a) % 8192);
    return s[26:0];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) bank_m[i] = i;
    mode_m = 1'b0;
  endtask

  task automatic idle();
    bus.cs = 0; bus.cpu_addr = '0; bus.cpu_data = '0;
    bus.cpu_req = 0; bus.cpu_wr = 0; bus.cpu_mreq = 0;
    bus.cpu_iorq = 0; bus.base_addr = '0;
  endtask

  task automatic drive(input vec_t v);
    bus.cpu_iorq = v.io; bus.cpu_mreq = v.mr; bus.cs = v.c;
    bus.cpu_wr = v.wr; bus.cpu_addr = v.a; bus.cpu_data = v.d;
    bus.base_addr = v.b; bus.cpu_req = 1'b1;
  endtask

  // One access: outputs checked inside the access, mode after the first edge.
  task automatic access(input vec_t v, input bit tbl, input string tag);
    bit ecs, ernw, em, mem;
    logic [26:0] ea;
    logic [7:0]  ed;
    @(negedge clk);
    drive(v);
    mem = v.c && v.mr && !v.io && in_win(v.a);
    if (mem && (!v.wr || mode_m)) begin
      ecs = 1; ernw = !v.wr; ea = phys_m(v.a, v.b);
      ed = v.wr ? v.d : 8'hFF;
    end else begin
      ecs = 0; ernw = 1; ea = NA; ed = 8'hFF;
    end
    if (tbl) begin
      ecs = v.exp_cs; ernw = v.exp_rnw; ea = v.exp_addr; ed = v.exp_d;
    end
    #1;
    chk({tag, ".cs"},   32'(bus.out_ram_cs), 32'(ecs));
    chk({tag, ".rnw"},  32'(bus.out_rnw),    32'(ernw));
    chk({tag, ".addr"}, 32'(bus.out_addr),   32'(ea));
    chk({tag, ".data"}, 32'(bus.out_data),   32'(ed));
    @(posedge clk);
    if (v.io && port_m(v.a))
      mode_m = v.wr;
    else if (mem && v.wr && !mode_m)
      bank_m[win_idx(v.a)] = int'(v.d) % (1 << BANK_BITS);
    em = tbl ? v.exp_mode : mode_m;
    #1;
    chk({tag, ".mode"}, 32'(bus.mode_ram), 32'(em));
    repeat (v.hold - 1) @(posedge clk);
    @(negedge clk);
    idle();
  endtask

  function automatic vec_t mk(bit io, bit mr, bit wr, logic [15:0] a,
                              logic [7:0] d, logic [26:0] b, bit ecs,
                              bit ernw, logic [26:0] ea, logic [7:0] ed,
                              bit em);
    vec_t v;
    v.io = io; v.mr = mr; v.c = 1; v.wr = wr; v.a = a; v.d = d;
    v.b = b; v.hold = 2; v.exp_cs = ecs; v.exp_rnw = ernw;
    v.exp_addr = ea; v.exp_d = ed; v.exp_mode = em;
    return v;
  endfunction

  vec_t tbl [$];
  vec_t v;

  initial begin
    tbl.push_back(mk(0,1,0,16'h6000,8'h00,27'h0,       1,1,27'h2000,  8'hFF,0));
    tbl.push_back(mk(0,1,1,16'h8000,8'h05,27'h0,       0,1,NA,        8'hFF,0));
    tbl.push_back(mk(0,1,0,16'h8123,8'h00,27'h0,       1,1,27'hA123,  8'hFF,0));
    tbl.push_back(mk(0,1,1,16'hA000,8'h25,27'h0,       0,1,NA,        8'hFF,0));
    tbl.push_back(mk(0,1,0,16'hA000,8'h00,27'h0,       1,1,27'hA000,  8'hFF,0));
    tbl.push_back(mk(0,1,0,16'hA000,8'h00,27'h100000,  1,1,27'h10A000,8'hFF,0));
    tbl.push_back(mk(1,0,1,16'h008E,8'h00,27'h0,       0,1,NA,        8'hFF,1));
    tbl.push_back(mk(0,1,1,16'h4001,8'hAA,27'h0,       1,0,27'h0001,  8'hAA,1));
    tbl.push_back(mk(0,1,0,16'h4001,8'h00,27'h0,       1,1,27'h0001,  8'hFF,1));
    tbl.push_back(mk(1,0,0,16'h008E,8'h00,27'h0,       0,1,NA,        8'hFF,0));
    tbl.push_back(mk(1,1,1,16'h408E,8'h33,27'h0,       0,1,NA,        8'hFF,1));
    tbl.push_back(mk(1,0,0,16'h008E,8'h00,27'h0,       0,1,NA,        8'hFF,0));

    idle();
    model_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.mode", 32'(bus.mode_ram),   32'd0);
    chk("rst.cs",   32'(bus.out_ram_cs), 32'd0);
    chk("rst.rnw",  32'(bus.out_rnw),    32'd1);
    chk("rst.addr", 32'(bus.out_addr),   32'(NA));
    chk("rst.data", 32'(bus.out_data),   32'hFF);
    @(negedge clk);
    reset = 1'b0;

    foreach (tbl[i]) access(tbl[i], 1'b1, $sformatf("tbl%0d", i));

    // Held cpu_req with changing data must load the bank only once.
    @(negedge clk);
    v = mk(0,1,1,16'h4000,8'h07,27'h0, 0,1,NA,8'hFF,0);
    drive(v);
    @(posedge clk);
    @(negedge clk);
    bus.cpu_data = 8'h09;
    repeat (4) @(posedge clk);
    @(negedge clk);
    idle();
    bank_m[0] = 7;
    access(mk(0,1,0,16'h4000,8'h00,27'h0, 1,1,27'hE000,8'hFF,0),
           1'b1, "hold");

    access(mk(1,0,1,16'h008F,8'h00,27'h0, 0,1,NA,8'hFF,MIRROR),
           1'b1, "mirror");
    access(mk(1,0,0,16'h008E,8'h00,27'h0, 0,1,NA,8'hFF,0), 1'b1, "in8e");

    for (int n = 0; n < 300; n++) begin
      int sel;
      v.io = ($urandom % 4) == 0;
      v.mr = v.io ? (($urandom % 4) == 0) : (($urandom % 8) != 0);
      v.c  = ($urandom % 8) != 0;
      v.wr = $urandom % 2;
      v.a  = 16'($urandom);
      if (v.io) begin
        sel = $urandom % 3;
        v.a[7:0] = (sel == 0) ? 8'h8E : (sel == 1) ? 8'h8F : v.a[7:0];
      end
      v.d    = 8'($urandom);
      v.b    = 27'($urandom);
      v.hold = 1 + $urandom % 3;
      access(v, 1'b0, $sformatf("rnd%0d", n));
    end

    // Reset during an access; the held write must not fire after release.
    access(mk(1,0,1,16'h008E,8'h00,27'h0, 0,1,NA,8'hFF,1), 1'b1, "pre");
    @(negedge clk);
    v = mk(0,1,0,16'h6000,8'h1C,27'h0, 0,1,NA,8'hFF,0);
    drive(v);
    reset = 1'b1;
    #1;
    chk("rstacc.cs",   32'(bus.out_ram_cs), 32'd0);
    chk("rstacc.addr", 32'(bus.out_addr),   32'(NA));
    @(posedge clk);
    @(negedge clk);
    bus.cpu_wr = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk("rstacc.mode", 32'(bus.mode_ram), 32'd0);
    @(negedge clk);
    idle();
    access(mk(0,1,0,16'h4000,8'h00,27'h0, 1,1,27'h0000,8'hFF,0), 1'b1, "rb0");
    access(mk(0,1,0,16'h6000,8'h00,27'h0, 1,1,27'h2000,8'hFF,0), 1'b1, "rb1");
    access(mk(0,1,1,16'h6000,8'h1C,27'h0, 0,1,NA,8'hFF,0), 1'b1, "wb1");
    access(mk(0,1,0,16'h6000,8'h00,27'h0, 1,1,27'h38000,8'hFF,0), 1'b1, "rb1n");

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
